// File: rtl/udp_cmd_ctrl.sv
// UDP command controller: decodes single-byte UDP command packets into
// all-frame / single-channel / continuous transfer requests for the CMOS
// frame sender, and tracks the transfer with a busy flag.
// Optional build macro CMD_TIMEOUT_EN adds a busy watchdog for ALL/SINGLE.
module udp_cmd_ctrl #(
  parameter int unsigned CH_NUM      = 8,
  parameter int unsigned PULSE_LEN   = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd125_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        udp_rec_en,
  input  logic [7:0]  udp_rec_data,
  input  logic [15:0] udp_rec_byte_num,
  input  logic        udp_rec_pkt_done,
  input  logic        frame_transfer_done,
  output logic        transfer_all_frame_flag,
  output logic        transfer_single_frame_flag,
  output logic [3:0]  transfer_cmos_sel,
  output logic        cont_mode,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [7:0] OP_ALL       = 8'h10;
  localparam logic [7:0] OP_CONT      = 8'h20;
  localparam logic [7:0] OP_STOP      = 8'h21;
  localparam logic [3:0] OP_SINGLE_HI = 4'h8;
  localparam logic [3:0] CH_MAX       = 4'(CH_NUM);
  localparam logic [7:0] PULSE_RELOAD = 8'(PULSE_LEN - 1);

  // Reject out-of-range parameterisations at elaboration
  if (CH_NUM < 1 || CH_NUM > 15 || PULSE_LEN < 1 || PULSE_LEN > 255 ||
      TIMEOUT_CYC == 32'd0) begin : g_param_check
    $error("udp_cmd_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALL,
    S_SINGLE,
    S_CONT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q;
  logic        op_vld_q;
  logic [7:0]  op_c;
  logic        op_vld_c;
  logic [7:0]  pulse_cnt_q;
  logic        all_flag_q, single_flag_q, cont_q, busy_q, err_q;
  logic [3:0]  sel_q, sel_d;
  logic        start_all_d, start_single_d, err_d;
  logic        timeout_c;

  // Opcode seen by the decoder; a byte arriving with pkt_done counts as first
  always_comb begin
    op_c     = op_vld_q ? op_q : udp_rec_data;
    op_vld_c = op_vld_q | udp_rec_en;
  end

  // Latch the first payload byte of each packet. A pkt_done with nothing
  // latched belongs to a packet cut by reset and is dropped silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 8'd0;
      op_vld_q <= 1'b0;
    end else if (udp_rec_pkt_done) begin
      op_vld_q <= 1'b0;
    end else if (udp_rec_en && !op_vld_q) begin
      op_q     <= udp_rec_data;
      op_vld_q <= 1'b1;
    end
  end

`ifdef CMD_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  // Watchdog: counts cycles spent in ALL/SINGLE, restarts on any state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= 32'd0;
    end else if ((state_d != state_q) ||
                 !(state_q == S_ALL || state_q == S_SINGLE)) begin
      to_cnt_q <= 32'd0;
    end else begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

  assign timeout_c = (state_q == S_ALL || state_q == S_SINGLE) &&
                     (to_cnt_q == TIMEOUT_CYC - 32'd1) && !frame_transfer_done;
`else
  assign timeout_c = 1'b0;
`endif

  // Next state and command decode; an accepted stop overrides everything
  always_comb begin
    state_d        = state_q;
    start_all_d    = 1'b0;
    start_single_d = 1'b0;
    err_d          = 1'b0;
    sel_d          = sel_q;

    if (frame_transfer_done) begin
      case (state_q)
        S_ALL, S_SINGLE: state_d = S_IDLE;
        S_CONT:          start_all_d = 1'b1;
        default:         ;
      endcase
    end

    if (timeout_c) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end

    if (udp_rec_pkt_done && op_vld_c) begin
      if (udp_rec_byte_num != 16'd1) begin
        err_d = 1'b1;
      end else if (op_c == OP_STOP) begin
        state_d     = S_IDLE;
        start_all_d = 1'b0;
        err_d       = 1'b0;
      end else if (state_q != S_IDLE) begin
        err_d = 1'b1;
      end else if (op_c == OP_ALL) begin
        state_d     = S_ALL;
        start_all_d = 1'b1;
      end else if (op_c == OP_CONT) begin
        state_d     = S_CONT;
        start_all_d = 1'b1;
      end else if (op_c[7:4] == OP_SINGLE_HI && op_c[3:0] != 4'd0 &&
                   op_c[3:0] <= CH_MAX) begin
        state_d        = S_SINGLE;
        start_single_d = 1'b1;
        sel_d          = op_c[3:0];
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // FSM state and registered outputs; an all-frame pulse always runs to length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pulse_cnt_q   <= 8'd0;
      all_flag_q    <= 1'b0;
      single_flag_q <= 1'b0;
      cont_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      sel_q         <= 4'd1;
    end else begin
      state_q       <= state_d;
      single_flag_q <= start_single_d;
      err_q         <= err_d;
      sel_q         <= sel_d;
      cont_q        <= (state_d == S_CONT);
      busy_q        <= (state_d != S_IDLE);
      if (start_all_d) begin
        all_flag_q  <= 1'b1;
        pulse_cnt_q <= PULSE_RELOAD;
      end else if (pulse_cnt_q != 8'd0) begin
        pulse_cnt_q <= pulse_cnt_q - 8'd1;
      end else begin
        all_flag_q  <= 1'b0;
      end
    end
  end

  assign transfer_all_frame_flag    = all_flag_q;
  assign transfer_single_frame_flag = single_flag_q;
  assign transfer_cmos_sel          = sel_q;
  assign cont_mode                  = cont_q;
  assign busy                       = busy_q;
  assign cmd_err                    = err_q;

endmodule

// File: tb/tb_udp_cmd_ctrl.sv
// Directed bench for udp_cmd_ctrl (CH_NUM=8, PULSE_LEN=4, TIMEOUT_CYC=100).
module tb_udp_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        udp_rec_en;
  logic [7:0]  udp_rec_data;
  logic [15:0] udp_rec_byte_num;
  logic        udp_rec_pkt_done;
  logic        frame_transfer_done;
  logic        transfer_all_frame_flag;
  logic        transfer_single_frame_flag;
  logic [3:0]  transfer_cmos_sel;
  logic        cont_mode;
  logic        busy;
  logic        cmd_err;

  int n_chk  = 0;
  int n_pass = 0;

  int   err_cnt      = 0;
  int   single_cnt   = 0;
  int   all_hi_cnt   = 0;
  int   all_rise_cnt = 0;
  logic all_prev     = 1'b0;

  udp_cmd_ctrl #(
    .CH_NUM      (8),
    .PULSE_LEN   (4),
    .TIMEOUT_CYC (32'd100)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .udp_rec_en                 (udp_rec_en),
    .udp_rec_data               (udp_rec_data),
    .udp_rec_byte_num           (udp_rec_byte_num),
    .udp_rec_pkt_done           (udp_rec_pkt_done),
    .frame_transfer_done        (frame_transfer_done),
    .transfer_all_frame_flag    (transfer_all_frame_flag),
    .transfer_single_frame_flag (transfer_single_frame_flag),
    .transfer_cmos_sel          (transfer_cmos_sel),
    .cont_mode                  (cont_mode),
    .busy                       (busy),
    .cmd_err                    (cmd_err)
  );

  always #5 clk = ~clk;

  // Output event counters, sampled mid-cycle
  always @(negedge clk) begin
    if (cmd_err) err_cnt++;
    if (transfer_single_frame_flag) single_cnt++;
    if (transfer_all_frame_flag) all_hi_cnt++;
    if (transfer_all_frame_flag && !all_prev) all_rise_cnt++;
    all_prev = transfer_all_frame_flag;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] op, input int nbytes, input bit with_ftd);
    for (int i = 0; i < nbytes; i++) begin
      udp_rec_en   = 1'b1;
      udp_rec_data = (i == 0) ? op : 8'hA5;
      tick();
    end
    udp_rec_en          = 1'b0;
    udp_rec_data        = 8'h00;
    udp_rec_pkt_done    = 1'b1;
    udp_rec_byte_num    = 16'(nbytes);
    frame_transfer_done = with_ftd;
    tick();
    udp_rec_pkt_done    = 1'b0;
    udp_rec_byte_num    = 16'd0;
    frame_transfer_done = 1'b0;
  endtask

  task automatic pulse_ftd();
    frame_transfer_done = 1'b1;
    tick();
    frame_transfer_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_all"},    32'(transfer_all_frame_flag), 32'd0);
    check({tag, "_single"}, 32'(transfer_single_frame_flag), 32'd0);
    check({tag, "_sel"},    32'(transfer_cmos_sel), 32'd1);
    check({tag, "_cont"},   32'(cont_mode), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_err"},    32'(cmd_err), 32'd0);
  endtask

  logic [7:0] rej_op  [4] = '{8'h89, 8'h10, 8'h55, 8'h80};
  int         rej_len [4] = '{1, 2, 1, 1};

  initial begin
    int e0, s0, r0, h0, n;
    rst                 = 1'b1;
    udp_rec_en          = 1'b0;
    udp_rec_data        = 8'h00;
    udp_rec_byte_num    = 16'd0;
    udp_rec_pkt_done    = 1'b0;
    frame_transfer_done = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst0");
    rst = 1'b0;
    tick();

    // All-frame command: 4-cycle flag, busy until transfer done
    h0 = all_hi_cnt; r0 = all_rise_cnt;
    send_pkt(8'h10, 1, 1'b0);
    check("all_flag_first", 32'(transfer_all_frame_flag), 32'd1);
    check("all_busy", 32'(busy), 32'd1);
    repeat (8) tick();
    check("all_flag_len", 32'(all_hi_cnt - h0), 32'd4);
    check("all_flag_once", 32'(all_rise_cnt - r0), 32'd1);
    check("all_busy_hold", 32'(busy), 32'd1);
    pulse_ftd();
    check("all_busy_clr", 32'(busy), 32'd0);

    // Single channel 3, then rejected 0x85 while busy
    s0 = single_cnt;
    send_pkt(8'h83, 1, 1'b0);
    check("sgl_flag", 32'(transfer_single_frame_flag), 32'd1);
    check("sgl_sel", 32'(transfer_cmos_sel), 32'd3);
    check("sgl_busy", 32'(busy), 32'd1);
    tick();
    check("sgl_flag_off", 32'(transfer_single_frame_flag), 32'd0);
    send_pkt(8'h85, 1, 1'b0);
    check("sgl_busy_err", 32'(cmd_err), 32'd1);
    check("sgl_busy_sel", 32'(transfer_cmos_sel), 32'd3);
    tick();
    check("sgl_err_off", 32'(cmd_err), 32'd0);
    check("sgl_flag_once", 32'(single_cnt - s0), 32'd1);
    pulse_ftd();
    check("sgl_busy_clr", 32'(busy), 32'd0);

    // Rejected packets: bad channel, wrong length, unknown opcode, channel 0
    for (int k = 0; k < 4; k++) begin
      e0 = err_cnt; r0 = all_rise_cnt; s0 = single_cnt;
      send_pkt(rej_op[k], rej_len[k], 1'b0);
      check($sformatf("rej%0d_err", k), 32'(cmd_err), 32'd1);
      repeat (3) tick();
      check($sformatf("rej%0d_errcnt", k), 32'(err_cnt - e0), 32'd1);
      check($sformatf("rej%0d_all", k), 32'(all_rise_cnt - r0), 32'd0);
      check($sformatf("rej%0d_sgl", k), 32'(single_cnt - s0), 32'd0);
      check($sformatf("rej%0d_busy", k), 32'(busy), 32'd0);
    end
    check("rej_sel_kept", 32'(transfer_cmos_sel), 32'd3);

    // Stop in IDLE and transfer-done in IDLE are silent no-ops
    e0 = err_cnt; r0 = all_rise_cnt;
    send_pkt(8'h21, 1, 1'b0);
    check("idle_stop_busy", 32'(busy), 32'd0);
    pulse_ftd();
    repeat (3) tick();
    check("idle_noop_err", 32'(err_cnt - e0), 32'd0);
    check("idle_noop_all", 32'(all_rise_cnt - r0), 32'd0);

    // Continuous mode: 1 + 3 pulses, stop coincident with 4th done wins
    e0 = err_cnt; r0 = all_rise_cnt; h0 = all_hi_cnt;
    send_pkt(8'h20, 1, 1'b0);
    check("cont_mode", 32'(cont_mode), 32'd1);
    check("cont_busy", 32'(busy), 32'd1);
    check("cont_flag", 32'(transfer_all_frame_flag), 32'd1);
    repeat (6) tick();
    for (int k = 0; k < 3; k++) begin
      pulse_ftd();
      repeat (6) tick();
    end
    check("cont_pulses", 32'(all_rise_cnt - r0), 32'd4);
    check("cont_hi", 32'(all_hi_cnt - h0), 32'd16);
    send_pkt(8'h21, 1, 1'b1);
    check("cont_stop_mode", 32'(cont_mode), 32'd0);
    check("cont_stop_busy", 32'(busy), 32'd0);
    repeat (6) tick();
    check("cont_stop_nopulse", 32'(all_rise_cnt - r0), 32'd4);
    check("cont_stop_noerr", 32'(err_cnt - e0), 32'd0);

    // Stop during an active pulse: pulse still runs full length
    h0 = all_hi_cnt;
    send_pkt(8'h20, 1, 1'b0);
    send_pkt(8'h21, 1, 1'b0);
    check("midstop_cont", 32'(cont_mode), 32'd0);
    check("midstop_flag", 32'(transfer_all_frame_flag), 32'd1);
    repeat (6) tick();
    check("midstop_len", 32'(all_hi_cnt - h0), 32'd4);

    // Watchdog behaviour on a single command with no completion
    e0 = err_cnt;
    send_pkt(8'h81, 1, 1'b0);
    check("wd_sel", 32'(transfer_cmos_sel), 32'd1);
`ifdef CMD_TIMEOUT_EN
    n = 0;
    while (busy && n < 300) begin
      n++;
      tick();
    end
    check("wd_busy_cycles", 32'(n), 32'd100);
    check("wd_err", 32'(cmd_err), 32'd1);
    tick();
    check("wd_err_once", 32'(err_cnt - e0), 32'd1);
`else
    n = 0;
    repeat (150) tick();
    check("wd_off_busy", 32'(busy), 32'd1);
    check("wd_off_noerr", 32'(err_cnt - e0), 32'd0);
    pulse_ftd();
    check("wd_off_clr", 32'(busy), 32'd0);
`endif

    // Asynchronous reset in the middle of an all-frame pulse
    send_pkt(8'h83, 1, 1'b0);
    pulse_ftd();
    check("pre_rst_sel", 32'(transfer_cmos_sel), 32'd3);
    send_pkt(8'h10, 1, 1'b0);
    tick();
    check("pre_rst_flag", 32'(transfer_all_frame_flag), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_async");

    // Packet straddling reset release is discarded without error
    tick();
    udp_rec_en   = 1'b1;
    udp_rec_data = 8'h10;
    tick();
    udp_rec_en   = 1'b0;
    rst          = 1'b0;
    tick();
    udp_rec_pkt_done = 1'b1;
    udp_rec_byte_num = 16'd1;
    tick();
    udp_rec_pkt_done = 1'b0;
    udp_rec_byte_num = 16'd0;
    check("cut_err", 32'(cmd_err), 32'd0);
    check("cut_flag", 32'(transfer_all_frame_flag), 32'd0);
    check("cut_busy", 32'(busy), 32'd0);
    send_pkt(8'h10, 1, 1'b0);
    check("post_rst_flag", 32'(transfer_all_frame_flag), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd1);
    pulse_ftd();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/udp_cmd_ctrl.md
UDP_CMD_CTRL -- requirements
Module: udp_cmd_ctrl

Interface
REQ-001 Parameter CH_NUM, default 8: number of selectable CMOS channels, 1..15.
REQ-002 Parameter PULSE_LEN, default 4: all-frame flag width in clk cycles, 1..255.
REQ-003 Parameter TIMEOUT_CYC, default 32'd125_000_000: busy watchdog limit in cycles.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 udp_rec_en  in  1  udp_rec_data valid this cycle.
REQ-007 udp_rec_data  in  8  received UDP payload byte.
REQ-008 udp_rec_byte_num  in  16  payload length, valid with udp_rec_pkt_done.
REQ-009 udp_rec_pkt_done  in  1  one-cycle end-of-packet strobe.
REQ-010 frame_transfer_done  in  1  one-cycle strobe: requested transfer finished.
REQ-011 transfer_all_frame_flag  out  1  high exactly PULSE_LEN cycles per accepted all-frame command.
REQ-012 transfer_single_frame_flag  out  1  one-cycle pulse per accepted single-channel command.
REQ-013 transfer_cmos_sel  out  4  selected channel, held until the next accepted single command.
REQ-014 cont_mode  out  1  high while continuous-transfer mode is active.
REQ-015 busy  out  1  high from command acceptance until transfer completion.
REQ-016 cmd_err  out  1  one-cycle pulse on a rejected packet.

Function
REQ-017 First byte of each packet (first udp_rec_en after reset or after the previous udp_rec_pkt_done) SHALL be latched as the opcode; later bytes are ignored.
REQ-018 Decode SHALL occur in the udp_rec_pkt_done cycle; outputs respond on the next clk edge (1-cycle latency).
REQ-019 Packet SHALL be valid only if udp_rec_byte_num == 1; otherwise cmd_err pulses and state is unchanged.
REQ-020 Opcodes: 0x10 all-frame; 0x8n single channel n; 0x20 continuous start; 0x21 stop; any other value -> cmd_err.
REQ-021 0x8n with n == 0 or n > CH_NUM SHALL give cmd_err; transfer_cmos_sel is unchanged.
REQ-022 FSM states: IDLE, ALL, SINGLE, CONT.
REQ-023 IDLE + 0x10 -> ALL, start PULSE_LEN flag; IDLE + valid 0x8n -> SINGLE, pulse single flag, load sel = n.
REQ-024 IDLE + 0x20 -> CONT with cont_mode=1; in CONT each frame_transfer_done re-issues an all-frame flag.
REQ-025 ALL/SINGLE + frame_transfer_done -> IDLE; busy = (state != IDLE).
REQ-026 0x10, 0x8n or 0x20 received while busy SHALL be rejected with cmd_err and no state change.
REQ-027 0x21 SHALL go to IDLE from any state with no cmd_err; 0x21 in IDLE is a no-op.
REQ-028 0x21 and frame_transfer_done in the same cycle: the stop wins; no new flag is issued.
REQ-029 An active all-frame flag pulse SHALL always complete its full PULSE_LEN length, even after a stop.
REQ-030 frame_transfer_done in IDLE SHALL be ignored.

Reset
REQ-031 rst high SHALL force state IDLE and clear the opcode latch and pulse counter immediately; outputs go to all flags 0, cont_mode 0, busy 0, cmd_err 0, transfer_cmos_sel 4'd1.
REQ-032 A packet in progress when rst deasserts SHALL be discarded until its udp_rec_pkt_done.

Configuration
REQ-033 Macro CMD_TIMEOUT_EN.
- Defined: a counter runs while in ALL or SINGLE. It clears on each state entry. When it reaches TIMEOUT_CYC without frame_transfer_done, the FSM returns to IDLE and cmd_err pulses once.
- Undefined: no counter is built, and ALL/SINGLE wait indefinitely.

Verification
REQ-034 Bench SHALL cover the following directed scenarios:
- 1-byte 0x10, PULSE_LEN=4: transfer_all_frame_flag high exactly 4 cycles starting 1 cycle after done; busy=1; frame_transfer_done -> busy=0.
- 1-byte 0x83, CH_NUM=8: single flag pulses 1 cycle; sel=3; a following 0x85 while busy -> cmd_err, sel stays 3.
- 0x89 with CH_NUM=8, 2-byte 0x10, opcode 0x55: each produces one cmd_err pulse and no flags.
- 0x20, then 3 x frame_transfer_done: 1 + 3 all-frame pulses; 0x21 coincident with the 4th done -> IDLE, no further pulse.
- CMD_TIMEOUT_EN with TIMEOUT_CYC=100: 0x81 and no done -> busy drops at cycle 100 with cmd_err; rst asserted mid-pulse -> all outputs reset values immediately.
